fir_tap_sequencer: RTL
======================

Name: fir_tap_sequencer

Overview:
- Control FSM for the FIR datapath; sequences one output sample per accepted input sample.
- Writes each new sample into the circular sample memory and loads the sample-pointer register with the current write pointer.
- Then steps TAPS coefficient/data address pairs into the MAC, waits for MAC pipeline drain, and presents the result under a valid/ready handshake.

Parameters:
- TAPS, 32, number of filter taps; legal range 1 to 2^ADDR_W.
- ADDR_W, 5, width of sample and coefficient addresses.
- MAC_LAT, 1, MAC pipeline depth in cycles (legal 0..7) between last mac_en and final accumulator value.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- in_valid  in  1  new input sample present on datapath.
- in_ready  out  1  sequencer can accept a sample.
- out_valid  out  1  accumulator holds a completed output.
- out_ready  in  1  consumer takes the output.
- mem_we  out  1  write strobe for sample memory at data_addr.
- ptr_ld  out  1  load strobe for the sample-pointer register.
- ptr_addr  out  ADDR_W  value loaded into the sample-pointer register.
- data_addr  out  ADDR_W  sample memory address.
- coef_addr  out  ADDR_W  coefficient ROM address.
- acc_clr  out  1  synchronous clear of MAC accumulator.
- mac_en  out  1  MAC accumulate enable.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- All outputs are registered. While rst=0, every output is 0, state=IDLE, wr_ptr=0, k=0.
- in_ready rises on the first clk edge after rst release.
- A handshake occurs on a clk edge where the signal pair is 1/1. No other edge counts.
- IDLE: in_ready=1. On input handshake: state=LOAD, in_ready=0.
- LOAD (1 cycle):
  - mem_we=1, data_addr=wr_ptr, acc_clr=1, ptr_ld=1, ptr_addr=wr_ptr, k=0.
  - Then state=MAC.
- MAC (exactly TAPS cycles):
  - mac_en=1, coef_addr=k, data_addr=(wr_ptr - k) mod 2^ADDR_W.
  - k increments each cycle. When k==TAPS-1, next state=DRAIN, or HOLD if MAC_LAT=0.
- DRAIN (MAC_LAT cycles): all strobes 0.
- HOLD:
  - out_valid=1 until output handshake.
  - On handshake: wr_ptr=(wr_ptr+1) mod 2^ADDR_W, out_valid=0, state=IDLE, in_ready=1 next cycle.
- Latency: input handshake at edge 0 gives LOAD strobes after edge 0 and out_valid after edge TAPS+1+MAC_LAT.
- Throughput: one sample per TAPS+3+MAC_LAT cycles with out_ready held high.
- Address wrap: subtraction and pointer increment are modulo 2^ADDR_W. With wr_ptr=2 and k=3, data_addr=31 (ADDR_W=5).
- in_valid outside IDLE is ignored; no sample is lost because in_ready=0.
- out_ready asserted before HOLD is legal; the handshake completes in the first HOLD cycle.
- out_ready held low stalls indefinitely in HOLD. No new input is accepted.
- Reset asserted mid-operation aborts immediately and asynchronously. All outputs go to 0 and wr_ptr goes to 0. The partial result is discarded.
- TAPS=1: MAC lasts one cycle with coef_addr=0.

Decomposition:
- Shared package fir_ctrl_pkg:
  - State enum: IDLE, LOAD, MAC, DRAIN, HOLD.
  - Default ADDR_W, TAPS, MAC_LAT constants.
  - Address-width typedef.
- Sub-module tap_counter: loadable modulo counter with clear, enable and terminal-count flag. Instantiated once for k and reused for the DRAIN count.

Test Plan:
- Reset release with in_valid=0 -> all outputs 0 during reset; in_ready=1 one edge after release; busy=0.
- Single sample, TAPS=32, MAC_LAT=1, out_ready=1 -> mem_we/acc_clr/ptr_ld one cycle with ptr_addr=0; then 32 mac_en cycles with coef_addr 0..31 and data_addr 0,31,30..1; out_valid after edge 34; wr_ptr becomes 1.
- Three back-to-back samples with out_ready=0 for 10 cycles on the first -> out_valid held 10 cycles; in_valid ignored meanwhile; ptr_addr sequence 0,1,2.
- Wrap: 33 samples -> 33rd LOAD has ptr_addr=0; during its MAC, data_addr for k=1 is 31.
- Reset pulsed low at MAC cycle 10 -> outputs 0 asynchronously; after release the next LOAD has ptr_addr=0.
- in_valid asserted continuously with out_ready toggling every cycle -> exactly one LOAD per output handshake; no double-accepts.

Source files
------------

// File: rtl/fir_ctrl_pkg.sv
// Shared types and default sizing for the FIR control path.
package fir_ctrl_pkg;

  localparam int DEF_ADDR_W  = 5;
  localparam int DEF_TAPS    = 32;
  localparam int DEF_MAC_LAT = 1;

  typedef logic [DEF_ADDR_W-1:0] addr_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    MAC,
    DRAIN,
    HOLD
  } state_e;

endpackage

// File: rtl/tap_counter.sv
// Loadable modulo counter with clear, enable and terminal-count compare.
// o_nxt exposes the value the counter takes at the next edge.
module tap_counter #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_ld,
  input  logic [W-1:0] i_ld_val,
  input  logic         i_en,
  input  logic [W-1:0] i_tc_val,
  output logic [W-1:0] o_nxt,
  output logic         o_tc
);

  logic [W-1:0] r_cnt;

  always_comb begin
    o_nxt = r_cnt;
    if (i_clr)
      o_nxt = '0;
    else if (i_ld)
      o_nxt = i_ld_val;
    else if (i_en)
      o_nxt = r_cnt + W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_cnt <= '0;
    else
      r_cnt <= o_nxt;
  end

  assign o_tc = (r_cnt == i_tc_val);

endmodule

// File: rtl/fir_tap_sequencer.sv
// Control FSM for the FIR datapath: one output per accepted input sample.
// Every output is a register loaded from the next-state decode.
module fir_tap_sequencer
  import fir_ctrl_pkg::*;
#(
  parameter int TAPS    = DEF_TAPS,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int MAC_LAT = DEF_MAC_LAT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              mem_we,
  output logic              ptr_ld,
  output logic [ADDR_W-1:0] ptr_addr,
  output logic [ADDR_W-1:0] data_addr,
  output logic [ADDR_W-1:0] coef_addr,
  output logic              acc_clr,
  output logic              mac_en,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] MAC_TC   = ADDR_W'(TAPS - 1);
  localparam logic [ADDR_W-1:0] DRAIN_TC = ADDR_W'((MAC_LAT > 0) ? MAC_LAT - 1 : 0);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [ADDR_W-1:0] r_wr_ptr;

  logic              r_in_ready, r_out_valid, r_mem_we, r_ptr_ld;
  logic              r_acc_clr, r_mac_en, r_busy;
  logic [ADDR_W-1:0] r_ptr_addr, r_data_addr, r_coef_addr;

  logic              w_in_ready, w_out_valid, w_mem_we, w_ptr_ld;
  logic              w_acc_clr, w_mac_en, w_busy;
  logic [ADDR_W-1:0] w_ptr_addr, w_data_addr, w_coef_addr;

  logic              w_hs_in, w_hs_out;
  logic              w_cnt_clr, w_cnt_en, w_cnt_tc;
  logic [ADDR_W-1:0] w_k_nxt, w_tc_val;

  assign w_hs_in  = r_in_ready & in_valid;
  assign w_hs_out = r_out_valid & out_ready;
  assign w_tc_val = (r_state == DRAIN) ? DRAIN_TC : MAC_TC;

  // One counter serves as tap index k in MAC and as the drain timer in DRAIN.
  tap_counter #(
    .W(ADDR_W)
  ) u_tap_counter (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (w_cnt_clr),
    .i_ld     (1'b0),
    .i_ld_val ('0),
    .i_en     (w_cnt_en),
    .i_tc_val (w_tc_val),
    .o_nxt    (w_k_nxt),
    .o_tc     (w_cnt_tc)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_clr   = 1'b0;
    w_cnt_en    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_hs_in) begin
          w_state_nxt = LOAD;
          w_cnt_clr   = 1'b1;
        end
      end
      LOAD: w_state_nxt = MAC;
      MAC: begin
        if (w_cnt_tc) begin
          w_state_nxt = (MAC_LAT == 0) ? HOLD : DRAIN;
          w_cnt_clr   = 1'b1;
        end else begin
          w_cnt_en = 1'b1;
        end
      end
      DRAIN: begin
        if (w_cnt_tc) begin
          w_state_nxt = HOLD;
          w_cnt_clr   = 1'b1;
        end else begin
          w_cnt_en = 1'b1;
        end
      end
      HOLD: begin
        if (w_hs_out)
          w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase

    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    w_mem_we    = 1'b0;
    w_ptr_ld    = 1'b0;
    w_acc_clr   = 1'b0;
    w_mac_en    = 1'b0;
    w_ptr_addr  = '0;
    w_data_addr = '0;
    w_coef_addr = '0;
    w_busy      = (w_state_nxt != IDLE);
    unique case (w_state_nxt)
      IDLE: w_in_ready = 1'b1;
      LOAD: begin
        w_mem_we    = 1'b1;
        w_acc_clr   = 1'b1;
        w_ptr_ld    = 1'b1;
        w_ptr_addr  = r_wr_ptr;
        w_data_addr = r_wr_ptr;
      end
      MAC: begin
        w_mac_en    = 1'b1;
        w_coef_addr = w_k_nxt;
        w_data_addr = r_wr_ptr - w_k_nxt;
      end
      HOLD:    w_out_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_wr_ptr    <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_mem_we    <= 1'b0;
      r_ptr_ld    <= 1'b0;
      r_acc_clr   <= 1'b0;
      r_mac_en    <= 1'b0;
      r_busy      <= 1'b0;
      r_ptr_addr  <= '0;
      r_data_addr <= '0;
      r_coef_addr <= '0;
    end else begin
      r_state     <= w_state_nxt;
      if (w_hs_out)
        r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      r_in_ready  <= w_in_ready;
      r_out_valid <= w_out_valid;
      r_mem_we    <= w_mem_we;
      r_ptr_ld    <= w_ptr_ld;
      r_acc_clr   <= w_acc_clr;
      r_mac_en    <= w_mac_en;
      r_busy      <= w_busy;
      r_ptr_addr  <= w_ptr_addr;
      r_data_addr <= w_data_addr;
      r_coef_addr <= w_coef_addr;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign mem_we    = r_mem_we;
  assign ptr_ld    = r_ptr_ld;
  assign ptr_addr  = r_ptr_addr;
  assign data_addr = r_data_addr;
  assign coef_addr = r_coef_addr;
  assign acc_clr   = r_acc_clr;
  assign mac_en    = r_mac_en;
  assign busy      = r_busy;

endmodule
